// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Drains a synchronous FIFO with 1-cycle read latency into a
//            valid/ready stream through a 2-entry skid buffer.
//            Optional statistics counters: FIFO_RD_STREAM_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_rd_stream #(
    parameter int N     = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_re,
    input  logic [N-1:0]     fifo_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N-1:0]     m_data,
    output logic             busy
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    logic [1:0]   r_occ;
    logic         r_pend;
    logic [N-1:0] r_buf0;
    logic [N-1:0] r_buf1;
    logic         w_pop;
    logic [2:0]   w_fill;

    assign m_valid = (r_occ != S0);
    assign m_data  = r_buf0;
    assign busy    = r_pend || m_valid;
    assign w_pop   = m_valid && m_ready;

    // Occupancy after this cycle, counting the word already in flight.
    assign w_fill  = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};

    // Gated by rst_n so the strobe is low throughout reset.
    assign fifo_re = rst_n && !fifo_empty && (w_fill < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= S0;
            r_pend <= 1'b0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            r_pend <= fifo_re;
            case ({r_pend, w_pop})
                2'b10: begin
                    case (r_occ)
                        S0: begin
                            r_buf0 <= fifo_out;
                            r_occ  <= S1;
                        end
                        S1: begin
                            r_buf1 <= fifo_out;
                            r_occ  <= S2;
                        end
                        default: ;
                    endcase
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == S2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_out;
                    end else begin
                        r_buf0 <= fifo_out;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_pend && (r_occ == S2) && !w_pop));

`ifdef FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_pop)
                word_cnt <= word_cnt + 1'b1;
            if (m_valid && !m_ready)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    // Counter width only matters when statistics are built in.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

`default_nettype wire
